bsr_meta_responder: RTL and testbench

Responder end of the BSR metadata read interface, serving scheduler reads (meta_raddr/meta_ren -> meta_rdata/meta_rvalid) from two on-chip tables: row_ptr at addresses [0, COL_BASE) and col_idx at [COL_BASE, COL_BASE+COL_DEPTH). Tables are filled by a load FSM from a valid/ready word stream (DMA side) and checked for BSR format errors while loading. Sits between the DMA/metadata loader and the BSR scheduler.

---
 rtl/bsr_meta_pkg.sv | 31 +++
 rtl/bsr_meta_responder_if.sv | 18 +
 rtl/bsr_meta_table.sv | 25 ++
 rtl/bsr_meta_responder.sv | 175 +++++++++++++++++
 tb/tb_bsr_meta_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bsr_meta_pkg.sv
// Shared types and helpers for the BSR metadata responder: load FSM states,
// read-region decode and default sizing.
package bsr_meta_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_COL_BASE = 128;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_PTR   = 3'd1,
    L_COL   = 3'd2,
    L_CHECK = 3'd3,
    L_READY = 3'd4
  } load_state_t;

  typedef enum logic [1:0] {
    REG_PTR  = 2'd0,
    REG_COL  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] ptr_depth,
                                            input logic [31:0] col_base,
                                            input logic [31:0] col_depth);
    if (addr < ptr_depth) return REG_PTR;
    if (addr >= col_base && addr < col_base + col_depth) return REG_COL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/bsr_meta_responder_if.sv
// Scheduler-side metadata read bus between the BSR scheduler (master) and
// the metadata responder (slave).
interface bsr_meta_responder_if #(parameter int DATA_W = 32) ();
  // Handshake: meta_ren is a one-cycle request, answered exactly one edge
  // later by meta_rvalid/meta_rdata. A response is consumed on any edge where
  // meta_rvalid && meta_ready; while meta_rvalid && !meta_ready the response
  // holds and any new meta_ren is dropped.
  logic [31:0]       meta_raddr;
  logic              meta_ren;
  logic [DATA_W-1:0] meta_rdata;
  logic              meta_rvalid;
  logic              meta_ready;

  modport master (output meta_raddr, meta_ren, meta_ready,
                  input  meta_rdata, meta_rvalid);
  modport slave  (input  meta_raddr, meta_ren, meta_ready,
                  output meta_rdata, meta_rvalid);
endinterface

// File: rtl/bsr_meta_table.sv
// Simple synchronous RAM: one write port, one registered read port whose
// output holds while re_i is low.
module bsr_meta_table #(
  parameter  int DEPTH = 128,
  parameter  int W     = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bsr_meta_responder.sv
// BSR metadata responder: loads row_ptr/col_idx tables from a word stream,
// checks BSR format, and serves 1-cycle-latency scheduler reads.
module bsr_meta_responder
  import bsr_meta_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PTR_DEPTH = 128,
  parameter int COL_BASE  = DEF_COL_BASE,
  parameter int COL_DEPTH = 1024,
  parameter int NT_MAX    = 1023
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic [$clog2(PTR_DEPTH)-1:0]   cfg_num_rows,
  input  logic [$clog2(COL_DEPTH+1)-1:0] cfg_nnz,
  input  logic [DATA_W-1:0]              ld_data,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  output logic                           tables_valid,
  output logic                           load_done,
  output logic                           err_fmt,
  output logic                           err_oor,
  output logic                           err_drop,
  bsr_meta_responder_if.slave            meta,
  output load_state_t                    dbg_state_o
);
  localparam int NR_W  = $clog2(PTR_DEPTH);
  localparam int NZ_W  = $clog2(COL_DEPTH + 1);
  localparam int CNT_W = (NZ_W > NR_W) ? NZ_W : NR_W;
  localparam int PA_W  = $clog2(PTR_DEPTH);
  localparam int CA_W  = $clog2(COL_DEPTH);

  load_state_t       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NR_W-1:0]   nrows_q;
  logic [NZ_W-1:0]   nnz_q;
  logic [DATA_W-1:0] prev_q;
  logic              tables_valid_q, load_done_q, err_fmt_q;

  logic              ld_fire, ptr_we, col_we, cfg_bad, chk_mismatch;
  logic [NR_W:0]     rows_p1;
  logic [CNT_W-1:0]  cnt_inc;

  assign ld_ready     = (state_q == L_PTR) || (state_q == L_COL);
  assign ld_fire      = ld_valid && ld_ready;
  assign ptr_we       = ld_fire && (state_q == L_PTR);
  assign col_we       = ld_fire && (state_q == L_COL);
  assign rows_p1      = {1'b0, cfg_num_rows} + (NR_W+1)'(1);
  assign cfg_bad      = (rows_p1 > (NR_W+1)'(PTR_DEPTH)) || (cfg_nnz > NZ_W'(COL_DEPTH));
  assign cnt_inc      = cnt_q + CNT_W'(1);
  // prev_q holds the final row_ptr word once L_PTR finishes.
  assign chk_mismatch = (prev_q != DATA_W'(nnz_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= L_IDLE;
      cnt_q          <= '0;
      nrows_q        <= '0;
      nnz_q          <= '0;
      prev_q         <= '0;
      tables_valid_q <= 1'b0;
      load_done_q    <= 1'b0;
      err_fmt_q      <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        L_IDLE, L_READY: begin
          if (load_start) begin
            tables_valid_q <= 1'b0;
            cnt_q          <= '0;
            nrows_q        <= cfg_num_rows;
            nnz_q          <= cfg_nnz;
            if (cfg_bad) begin
              err_fmt_q   <= 1'b1;
              load_done_q <= 1'b1;
              state_q     <= L_IDLE;
            end else begin
              err_fmt_q <= 1'b0;
              state_q   <= L_PTR;
            end
          end
        end
        L_PTR: begin
          if (ld_fire) begin
            prev_q <= ld_data;
            if ((cnt_q == '0 && ld_data != '0) || (cnt_q != '0 && ld_data < prev_q))
              err_fmt_q <= 1'b1;
            if (cnt_q == CNT_W'(nrows_q)) begin
              cnt_q   <= '0;
              state_q <= (nnz_q == '0) ? L_CHECK : L_COL;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        L_COL: begin
          if (ld_fire) begin
            if (ld_data > DATA_W'(NT_MAX)) err_fmt_q <= 1'b1;
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_W'(nnz_q)) state_q <= L_CHECK;
          end
        end
        L_CHECK: begin
          err_fmt_q      <= err_fmt_q | chk_mismatch;
          tables_valid_q <= !(err_fmt_q | chk_mismatch);
          load_done_q    <= 1'b1;
          state_q        <= L_READY;
        end
        default: state_q <= L_IDLE;
      endcase
    end
  end

  // Read path: RAM output registers give the 1-cycle latency; sel_q picks
  // which table (or zero) drives meta_rdata and holds with the RAM outputs.
  region_t           rd_region, sel_q;
  logic              rvalid_q, err_oor_q, err_drop_q, stall, accept;
  logic              ptr_re, col_re;
  logic [PA_W-1:0]   ptr_raddr;
  logic [CA_W-1:0]   col_raddr;
  logic [DATA_W-1:0] ptr_rd, col_rd;

  assign rd_region = decode_region(meta.meta_raddr, 32'(PTR_DEPTH), 32'(COL_BASE), 32'(COL_DEPTH));
  assign stall     = rvalid_q && !meta.meta_ready;
  assign accept    = meta.meta_ren && !stall;
  assign ptr_re    = accept && tables_valid_q && (rd_region == REG_PTR);
  assign col_re    = accept && tables_valid_q && (rd_region == REG_COL);
  assign ptr_raddr = meta.meta_raddr[PA_W-1:0];
  assign col_raddr = CA_W'(meta.meta_raddr - 32'(COL_BASE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      sel_q      <= REG_NONE;
      err_oor_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else if (stall) begin
      if (meta.meta_ren) err_drop_q <= 1'b1;
    end else if (meta.meta_ren) begin
      rvalid_q <= 1'b1;
      sel_q    <= tables_valid_q ? rd_region : REG_NONE;
      if (!tables_valid_q || rd_region == REG_NONE) err_oor_q <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  bsr_meta_table #(.DEPTH(PTR_DEPTH), .W(DATA_W)) u_row_ptr (
    .clk(clk), .we_i(ptr_we), .waddr_i(cnt_q[PA_W-1:0]), .wdata_i(ld_data),
    .re_i(ptr_re), .raddr_i(ptr_raddr), .rdata_o(ptr_rd)
  );

  bsr_meta_table #(.DEPTH(COL_DEPTH), .W(DATA_W)) u_col_idx (
    .clk(clk), .we_i(col_we), .waddr_i(cnt_q[CA_W-1:0]), .wdata_i(ld_data),
    .re_i(col_re), .raddr_i(col_raddr), .rdata_o(col_rd)
  );

  always_comb begin
    meta.meta_rdata = '0;
    case (sel_q)
      REG_PTR: meta.meta_rdata = ptr_rd;
      REG_COL: meta.meta_rdata = col_rd;
      default: meta.meta_rdata = '0;
    endcase
  end

  assign meta.meta_rvalid = rvalid_q;
  assign tables_valid     = tables_valid_q;
  assign load_done        = load_done_q;
  assign err_fmt          = err_fmt_q;
  assign err_oor          = err_oor_q;
  assign err_drop         = err_drop_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_bsr_meta_responder.sv
// Directed bench for bsr_meta_responder: table loads, read vectors, format
// errors, backpressure and reset in the middle of a load.
module tb_bsr_meta_responder;
  import bsr_meta_pkg::*;

  logic        clk, rst_n, load_start, ld_valid, ld_ready;
  logic [6:0]  cfg_num_rows;
  logic [10:0] cfg_nnz;
  logic [31:0] ld_data;
  logic        tables_valid, load_done, err_fmt, err_oor, err_drop;
  load_state_t dbg_state;

  bsr_meta_responder_if #(.DATA_W(32)) mif ();

  bsr_meta_responder dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .cfg_num_rows(cfg_num_rows), .cfg_nnz(cfg_nnz),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .tables_valid(tables_valid), .load_done(load_done),
    .err_fmt(err_fmt), .err_oor(err_oor), .err_drop(err_drop),
    .meta(mif), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] ld_words[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_oor;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver: load_start pulse, then stream ld_words, then wait for load_done
  task automatic do_load(input int nrows, input int nnz);
    int idx, guard;
    bit done;
    @(negedge clk);
    load_start = 1'b1; cfg_num_rows = 7'(nrows); cfg_nnz = 11'(nnz);
    @(negedge clk);
    load_start = 1'b0;
    idx = 0; guard = 0;
    while (idx < ld_words.size() && guard < 200) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = ld_words[idx];
      if (ld_ready) idx++;
      guard++;
    end
    done = 1'b0; guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      ld_valid = 1'b0;
      if (load_done) done = 1'b1;
      guard++;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL load_done_timeout: got 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    @(negedge clk);
    mif.meta_ren = 1'b1; mif.meta_raddr = addr;
    @(negedge clk);
    mif.meta_ren = 1'b0;
  endtask

  task automatic load_good();
    ld_words = '{32'd0, 32'd2, 32'd2, 32'd3, 32'd5, 32'd1, 32'd7};
    do_load(3, 3);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] b2b_addr[4];
    logic [31:0] b2b_exp[4];
    vecs[0] = '{32'd1,    32'd2, 1'b0};
    vecs[1] = '{32'd130,  32'd7, 1'b0};
    vecs[2] = '{32'd0,    32'd0, 1'b0};
    vecs[3] = '{32'd3,    32'd3, 1'b0};
    vecs[4] = '{32'd128,  32'd5, 1'b0};
    vecs[5] = '{32'd129,  32'd1, 1'b0};
    vecs[6] = '{32'd2,    32'd2, 1'b0};
    vecs[7] = '{32'd2000, 32'd0, 1'b1};
    vecs[8] = '{32'd1152, 32'd0, 1'b1};
    vecs[9] = '{32'd130,  32'd7, 1'b1};
    b2b_addr = '{32'd0, 32'd1, 32'd128, 32'd129};
    b2b_exp  = '{32'd0, 32'd2, 32'd5,   32'd1};

    rst_n = 1'b0; load_start = 1'b0; cfg_num_rows = '0; cfg_nnz = '0;
    ld_data = '0; ld_valid = 1'b0;
    mif.meta_raddr = '0; mif.meta_ren = 1'b0; mif.meta_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 0);
    check("rst_tables_valid", 32'(tables_valid), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_errs", {29'd0, err_fmt, err_oor, err_drop}, 0);
    check("rst_rvalid", 32'(mif.meta_rvalid), 0);
    check("rst_rdata", mif.meta_rdata, 0);
    check("rst_state", 32'(dbg_state), 32'(L_IDLE));
    rst_n = 1'b1;

    // good load
    load_good();
    check("good_load_done", 32'(load_done), 1);
    check("good_tables_valid", 32'(tables_valid), 1);
    check("good_err_fmt", 32'(err_fmt), 0);
    check("good_state", 32'(dbg_state), 32'(L_READY));
    @(negedge clk);
    check("good_load_done_pulse", 32'(load_done), 0);

    // read vectors
    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].addr);
      check($sformatf("vec%0d_rvalid", i), 32'(mif.meta_rvalid), 1);
      check($sformatf("vec%0d_rdata", i), mif.meta_rdata, vecs[i].exp_data);
      check($sformatf("vec%0d_oor", i), 32'(err_oor), 32'(vecs[i].exp_oor));
      check($sformatf("vec%0d_tables_valid", i), 32'(tables_valid), 1);
    end

    // back-to-back reads on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("b2b%0d_rvalid", k-1), 32'(mif.meta_rvalid), 1);
        check($sformatf("b2b%0d_rdata", k-1), mif.meta_rdata, b2b_exp[k-1]);
      end
      mif.meta_ren = 1'b1; mif.meta_raddr = b2b_addr[k];
    end
    @(negedge clk);
    mif.meta_ren = 1'b0;
    check("b2b3_rvalid", 32'(mif.meta_rvalid), 1);
    check("b2b3_rdata", mif.meta_rdata, b2b_exp[3]);
    @(negedge clk);
    check("b2b_idle_rvalid", 32'(mif.meta_rvalid), 0);
    check("b2b_idle_rdata_hold", mif.meta_rdata, 32'd1);

    // backpressure: response held, new request dropped
    @(negedge clk);
    mif.meta_ren = 1'b1; mif.meta_raddr = 32'd130; mif.meta_ready = 1'b0;
    @(negedge clk);
    check("bp_first_rvalid", 32'(mif.meta_rvalid), 1);
    check("bp_first_rdata", mif.meta_rdata, 32'd7);
    check("bp_first_drop", 32'(err_drop), 0);
    mif.meta_raddr = 32'd1;
    @(negedge clk);
    check("bp_hold_rvalid", 32'(mif.meta_rvalid), 1);
    check("bp_hold_rdata", mif.meta_rdata, 32'd7);
    check("bp_drop", 32'(err_drop), 1);
    mif.meta_ren = 1'b0; mif.meta_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rvalid", 32'(mif.meta_rvalid), 0);
    check("bp_release_rdata", mif.meta_rdata, 32'd7);

    // oversize cfg_nnz at load_start
    @(negedge clk);
    load_start = 1'b1; cfg_num_rows = 7'd3; cfg_nnz = 11'd1025;
    @(negedge clk);
    load_start = 1'b0;
    check("badcfg_load_done", 32'(load_done), 1);
    check("badcfg_err_fmt", 32'(err_fmt), 1);
    check("badcfg_tables_valid", 32'(tables_valid), 0);
    check("badcfg_state", 32'(dbg_state), 32'(L_IDLE));
    @(negedge clk);
    check("badcfg_done_pulse", 32'(load_done), 0);

    // empty matrix: K=0, nnz=0 skips the col phase
    ld_words = '{32'd0};
    do_load(0, 0);
    check("empty_tables_valid", 32'(tables_valid), 1);
    check("empty_err_fmt", 32'(err_fmt), 0);

    // col_idx above NT_MAX
    ld_words = '{32'd0, 32'd1, 32'd1024};
    do_load(1, 1);
    check("ntmax_err_fmt", 32'(err_fmt), 1);
    check("ntmax_tables_valid", 32'(tables_valid), 0);

    // non-monotonic row_ptr after a clean reset
    pulse_reset();
    check("prefmt_err_oor", 32'(err_oor), 0);
    ld_words = '{32'd0, 32'd3, 32'd2, 32'd3, 32'd5, 32'd1, 32'd7};
    do_load(3, 3);
    check("fmt_err_fmt", 32'(err_fmt), 1);
    check("fmt_tables_valid", 32'(tables_valid), 0);
    do_read(32'd0);
    check("fmt_read_rvalid", 32'(mif.meta_rvalid), 1);
    check("fmt_read_rdata", mif.meta_rdata, 0);
    check("fmt_read_oor", 32'(err_oor), 1);

    // async reset after two row_ptr words, then a full reload
    load_good();
    @(negedge clk);
    load_start = 1'b1; cfg_num_rows = 7'd3; cfg_nnz = 11'd3;
    @(negedge clk);
    load_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'd0;
    @(negedge clk);
    ld_data = 32'd2;
    @(negedge clk);
    ld_valid = 1'b0;
    check("midload_state", 32'(dbg_state), 32'(L_PTR));
    rst_n = 1'b0;
    #1;
    check("midrst_ld_ready", 32'(ld_ready), 0);
    check("midrst_tables_valid", 32'(tables_valid), 0);
    check("midrst_errs", {29'd0, err_fmt, err_oor, err_drop}, 0);
    check("midrst_rvalid", 32'(mif.meta_rvalid), 0);
    check("midrst_state", 32'(dbg_state), 32'(L_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    load_good();
    check("reload_tables_valid", 32'(tables_valid), 1);
    check("reload_err_fmt", 32'(err_fmt), 0);
    do_read(32'd130);
    check("reload_read_rdata", mif.meta_rdata, 32'd7);
    do_read(32'd1);
    check("reload_read_ptr", mif.meta_rdata, 32'd2);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
